// File: rtl/adf4158_serial_rx_pkg.sv
// ----------------------------------------------------------------------------
// adf4158_serial_rx_pkg
//   Shared constants for the ADF4158 3-wire receive monitor: frame width,
//   shadow-file size, control-bit codes, the sub-register select bit and the
//   shadow slot assignments of the double-buffered R5/R6 registers.
//   slot_of() maps a frame's control bits and select bit to its shadow slot.
// ----------------------------------------------------------------------------
package adf4158_serial_rx_pkg;

    localparam int WORD_BITS  = 32;
    localparam int NUM_SLOTS  = 10;
    localparam int CNT_BITS   = 6;
    localparam int SUBSEL_BIT = 23;

    typedef enum logic [2:0] {
        CTRL_R0 = 3'd0,
        CTRL_R1 = 3'd1,
        CTRL_R2 = 3'd2,
        CTRL_R3 = 3'd3,
        CTRL_R4 = 3'd4,
        CTRL_R5 = 3'd5,
        CTRL_R6 = 3'd6,
        CTRL_R7 = 3'd7
    } ctrl_e;

    localparam logic [3:0] SLOT_R5_0 = 4'd5;
    localparam logic [3:0] SLOT_R5_1 = 4'd6;
    localparam logic [3:0] SLOT_R6_0 = 4'd7;
    localparam logic [3:0] SLOT_R6_1 = 4'd8;
    localparam logic [3:0] SLOT_R7   = 4'd9;

    // R0..R4 map straight onto slots 0..4; R5 and R6 each carry two
    // physical registers selected by bit 23 of the frame.
    function automatic logic [3:0] slot_of(input logic [2:0] ctrl, input logic subsel);
        logic [3:0] slot;
        slot = {1'b0, ctrl};
        case (ctrl_e'(ctrl))
            CTRL_R5: slot = subsel ? SLOT_R5_1 : SLOT_R5_0;
            CTRL_R6: slot = subsel ? SLOT_R6_1 : SLOT_R6_0;
            CTRL_R7: slot = SLOT_R7;
            default: slot = {1'b0, ctrl};
        endcase
        return slot;
    endfunction

endpackage

// File: rtl/adf4158_serial_rx_sync_edge.sv
// ----------------------------------------------------------------------------
// adf4158_serial_rx_sync_edge
//   STAGES-deep flip-flop synchronizer for one asynchronous bus pin, plus
//   single-cycle rise/fall pulses derived from the synchronized level.
// Ports
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   d     in  raw pin
//   q     out synchronized level
//   rise  out one-cycle pulse, q went 0->1
//   fall  out one-cycle pulse, q went 1->0
// ----------------------------------------------------------------------------
module adf4158_serial_rx_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // NOTE: registers are assigned with <= so every flop samples the values
    // from before the edge; blocking = here would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/adf4158_serial_rx.sv
// ----------------------------------------------------------------------------
// adf4158_serial_rx
//   Receive side of the ADF4158 SCLK/DATA/LE programming bus. The bus is
//   oversampled on clk_i, MSB-first words are shifted in on SCLK rises while
//   LE is low, and an LE rise commits a complete frame into a 10-slot shadow
//   register file selected by the control bits (and bit 23 for R5/R6).
// Ports
//   clk_i, rst_i   system clock, asynchronous active-high reset
//   ce_i           chip enable (low = powered down, bus ignored)
//   sclk_i         serial clock, data taken on its rising edge
//   sdata_i        serial data, MSB first
//   le_i           load enable, low while shifting, rise commits
//   rd_slot_i      shadow read index; rd_data_o is 0 for indices above 9
//   rd_data_o      combinational shadow read
//   word_o/slot_o  last committed word and its slot
//   valid_o        one-cycle pulse when word_o/slot_o update
//   frame_err_o    one-cycle pulse when LE rose on a wrong bit count
//   loaded_o       per-slot written-since-reset flags
//   all_loaded_o   every slot written
// ----------------------------------------------------------------------------
module adf4158_serial_rx #(
    parameter int WORD_BITS   = adf4158_serial_rx_pkg::WORD_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ce_i,
    input  logic                 sclk_i,
    input  logic                 sdata_i,
    input  logic                 le_i,
    input  logic [3:0]           rd_slot_i,
    output logic [WORD_BITS-1:0] rd_data_o,
    output logic [WORD_BITS-1:0] word_o,
    output logic [3:0]           slot_o,
    output logic                 valid_o,
    output logic                 frame_err_o,
    output logic [9:0]           loaded_o,
    output logic                 all_loaded_o
);

    import adf4158_serial_rx_pkg::*;

    logic sclk_s, sclk_rise, sclk_fall;
    logic sdata_s, sdata_rise, sdata_fall;
    logic le_s, le_rise, le_fall;
    logic ce_s, ce_rise, ce_fall;

    // All four pins share the same synchronizer depth so that their relative
    // timing on the bus is preserved after synchronization.
    adf4158_serial_rx_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk_i), .rst(rst_i), .d(sclk_i), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    adf4158_serial_rx_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdata (
        .clk(clk_i), .rst(rst_i), .d(sdata_i), .q(sdata_s), .rise(sdata_rise), .fall(sdata_fall)
    );
    // LE idles high between frames; starting its synchronizer high keeps a
    // bus that is already idle at reset release from looking like a commit.
    adf4158_serial_rx_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_le (
        .clk(clk_i), .rst(rst_i), .d(le_i), .q(le_s), .rise(le_rise), .fall(le_fall)
    );
    adf4158_serial_rx_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ce (
        .clk(clk_i), .rst(rst_i), .d(ce_i), .q(ce_s), .rise(ce_rise), .fall(ce_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_s, sclk_fall, sdata_rise, sdata_fall, ce_rise, ce_fall};

    logic [WORD_BITS-1:0] sr;
    logic [CNT_BITS-1:0]  bit_cnt;
    logic [WORD_BITS-1:0] shadow [NUM_SLOTS];
    logic                 shift_en;
    logic                 commit_en;
    logic                 frame_ok;
    logic [3:0]           new_slot;

    // A shift needs LE low in the same synced cycle, so an SCLK rise that
    // coincides with the LE rise is dropped and the commit uses the old count.
    assign shift_en  = sclk_rise & ~le_s & ce_s;
    assign commit_en = le_rise & ce_s;
    assign frame_ok  = (bit_cnt == CNT_BITS'(WORD_BITS));
    assign new_slot  = slot_of(sr[2:0], sr[SUBSEL_BIT]);

    // Bit counter saturates so an overlong frame can never wrap back to a
    // legal count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_cnt <= '0;
        end else if (!ce_s || le_rise) begin
            bit_cnt <= '0;
        end else if (le_fall) begin
            bit_cnt <= shift_en ? CNT_BITS'(1) : '0;
        end else if (shift_en && bit_cnt != '1) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr <= '0;
        end else if (shift_en) begin
            sr <= {sr[WORD_BITS-2:0], sdata_s};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_o      <= '0;
            slot_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            loaded_o    <= '0;
        end else begin
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            if (commit_en) begin
                if (frame_ok) begin
                    word_o             <= sr;
                    slot_o             <= new_slot;
                    valid_o            <= 1'b1;
                    loaded_o[new_slot] <= 1'b1;
                end else begin
                    frame_err_o <= 1'b1;
                end
            end
        end
    end

    // NOTE: the shadow file is reset because reads of never-written slots
    // must return 0; that forces flops here rather than an inferred RAM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                shadow[i] <= '0;
            end
        end else if (commit_en && frame_ok) begin
            shadow[new_slot] <= sr;
        end
    end

    // NOTE: rd_data_o gets a default before the range test so the
    // combinational read cannot infer a latch for indices 10..15.
    always_comb begin
        rd_data_o = '0;
        if (rd_slot_i < 4'(NUM_SLOTS)) begin
            rd_data_o = shadow[rd_slot_i];
        end
    end

    assign all_loaded_o = &loaded_o;

endmodule

// File: tb/tb_adf4158_serial_rx.sv
`timescale 1ns/1ps
module tb_adf4158_serial_rx;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        sclk;
    logic        sdata;
    logic        le;
    logic [3:0]  rd_slot;
    logic [31:0] rd_data;
    logic [31:0] word;
    logic [3:0]  slot;
    logic        valid;
    logic        frame_err;
    logic [9:0]  loaded;
    logic        all_loaded;

    adf4158_serial_rx #(.WORD_BITS(32), .SYNC_STAGES(SYNC)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ce_i        (ce),
        .sclk_i      (sclk),
        .sdata_i     (sdata),
        .le_i        (le),
        .rd_slot_i   (rd_slot),
        .rd_data_o   (rd_data),
        .word_o      (word),
        .slot_o      (slot),
        .valid_o     (valid),
        .frame_err_o (frame_err),
        .loaded_o    (loaded),
        .all_loaded_o(all_loaded)
    );

    always #12.5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model: bus-level view of what the receiver should hold.
    logic [31:0] m_shadow [10];
    logic [9:0]  m_loaded;
    logic [31:0] m_word;
    logic [3:0]  m_slot;
    logic [31:0] m_sr;
    int          m_count;
    bit          m_ce;

    typedef struct {
        bit          is_err;
        logic [31:0] word;
        logic [3:0]  slot;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    function automatic logic [3:0] ref_slot(input logic [31:0] w);
        int c = int'(w[2:0]);
        int s = int'(w[23]);
        if (c < 5)  return 4'(c);
        if (c == 5) return 4'(5 + s);
        if (c == 6) return 4'(7 + s);
        return 4'd9;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 10; i++) m_shadow[i] = '0;
        m_loaded = '0;
        m_word   = '0;
        m_slot   = '0;
        m_sr     = '0;
        m_count  = 0;
    endtask

    task automatic start_frame();
        le   = 1'b0;
        sclk = 1'b0;
        tick();
        m_count = 0;
    endtask

    // 20 MHz SCLK: one clk_i cycle low with data set up, one cycle high.
    task automatic shift_bits(input logic [63:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sdata = bits[i];
            sclk  = 1'b0;
            tick();
            sclk  = 1'b1;
            tick();
            if (m_ce) begin
                m_sr = {m_sr[30:0], bits[i]};
                if (m_count < 63) m_count++;
            end
        end
        sclk = 1'b0;
    endtask

    task automatic end_frame();
        exp_t e;
        sclk = 1'b0;
        le   = 1'b1;
        if (m_ce) begin
            e.cyc = cyc + SYNC + 1;
            if (m_count == 32) begin
                m_word             = m_sr;
                m_slot             = ref_slot(m_sr);
                m_shadow[m_slot]   = m_sr;
                m_loaded[m_slot]   = 1'b1;
                e.is_err           = 1'b0;
            end else begin
                e.is_err = 1'b1;
            end
            e.word = m_word;
            e.slot = m_slot;
            exp_q.push_back(e);
        end
        m_count = 0;
        tick();
    endtask

    task automatic send_word(input logic [31:0] w);
        start_frame();
        shift_bits({32'd0, w}, 32);
        end_frame();
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (4) tick();
    endtask

    task automatic check_shadows(input string tag);
        for (int i = 0; i < 16; i++) begin
            rd_slot = 4'(i);
            #1;
            check($sformatf("%s_rd%0d", tag, i), rd_data, (i < 10) ? m_shadow[i] : 32'd0);
        end
        check({tag, "_loaded"}, {22'd0, loaded}, {22'd0, m_loaded});
        check({tag, "_all_loaded"}, {31'd0, all_loaded}, {31'd0, &m_loaded});
        rd_slot = 4'd0;
    endtask

    function automatic logic [31:0] rand_word(input logic [2:0] ctrl, input logic b23);
        logic [31:0] w;
        w      = $urandom;
        w[2:0] = ctrl;
        w[23]  = b23;
        return w;
    endfunction

    // Monitor: every output pulse must match the oldest pending expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b at cycle %0d, expected none",
                             valid, frame_err, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", {30'd0, frame_err, valid}, e.is_err ? 32'd2 : 32'd1);
                    check("word_o", word, e.word);
                    check("slot_o", {28'd0, slot}, {28'd0, e.slot});
                    check("pulse_latency", cyc, e.cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] w;
        int          n;
        logic [2:0]  ctrls [10];
        logic        b23s  [10];

        rst = 1'b1; ce = 1'b1; sclk = 1'b0; sdata = 1'b0; le = 1'b1; rd_slot = 4'd0;
        m_ce = 1'b1;
        model_clear();
        repeat (3) tick();
        rst = 1'b0;
        repeat (4) tick();

        // Reset state
        check("rst_word_o", word, 32'd0);
        check("rst_slot_o", {28'd0, slot}, 32'd0);
        check("rst_pulses", {30'd0, frame_err, valid}, 32'd0);
        check("rst_loaded", {22'd0, loaded}, 32'd0);
        check("rst_all_loaded", {31'd0, all_loaded}, 32'd0);
        check("rst_rd0", rd_data, 32'd0);

        // Single known word into R0
        send_word(32'h8001_0848);
        drain();
        check("r0_word_o", word, 32'h8001_0848);
        rd_slot = 4'd0;
        #1;
        check("r0_rd0", rd_data, 32'h8001_0848);

        // Full programmer init sequence R7, R6(1), R6(0), R5(1), R5(0), R4..R0, back to back
        ctrls = '{3'd7, 3'd6, 3'd6, 3'd5, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        b23s  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            send_word(rand_word(ctrls[i], b23s[i]));
        end
        drain();
        check("init_all_loaded", {31'd0, all_loaded}, 32'd1);
        check_shadows("init");

        // R5 sub-register select
        send_word(rand_word(3'd5, 1'b1));
        check("r5_sel1_slot", {28'd0, ref_slot(m_word)}, 32'd6);
        send_word(rand_word(3'd5, 1'b0));
        check("r5_sel0_slot", {28'd0, ref_slot(m_word)}, 32'd5);
        drain();
        check_shadows("r5");

        // Short and long frames
        start_frame();
        shift_bits({$urandom, $urandom}, 31);
        end_frame();
        drain();
        start_frame();
        shift_bits({$urandom, $urandom}, 40);
        end_frame();
        drain();
        check_shadows("badlen");

        // ce drops mid-frame: LE rise must be ignored
        start_frame();
        shift_bits({32'd0, $urandom}, 16);
        ce = 1'b0;
        m_ce = 1'b0;
        m_count = 0;
        repeat (3) tick();
        end_frame();
        repeat (8) tick();
        drain();
        ce = 1'b1;
        m_ce = 1'b1;
        repeat (4) tick();
        send_word(rand_word(3'd2, $urandom_range(0, 1) == 1));
        drain();
        check_shadows("ce");

        // Randomized frames with occasional bad lengths and idle gaps
        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 6))
                0:       n = 31;
                1:       n = 33;
                2:       n = 40;
                default: n = 32;
            endcase
            w = rand_word(3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
            start_frame();
            shift_bits((n == 32) ? {32'd0, w} : {$urandom, $urandom}, n);
            end_frame();
            repeat ($urandom_range(0, 3)) tick();
        end
        drain();
        check_shadows("rand");

        // Reset mid-frame, then a partial frame
        start_frame();
        shift_bits({32'd0, $urandom}, 20);
        rst = 1'b1;
        #1;
        check("midrst_loaded_async", {22'd0, loaded}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        model_clear();
        tick();
        shift_bits({32'd0, $urandom}, 12);
        end_frame();
        drain();
        check("midrst_loaded", {22'd0, loaded}, 32'd0);
        check_shadows("midrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
